fft_read_engine: RTL and testbench

FFT_READ_ENGINE -- requirements
Module: fft_read_engine

---
 rtl/fft_pkg.sv | 78 +++++++
 rtl/fft_rsp_fifo.sv | 48 ++++
 rtl/fft_read_engine.sv | 167 ++++++++++++++++
 tb/tb_fft_read_engine.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - CSR word types, FSM states and CCI-P style channel structs for the FFT read engine
package fft_pkg;

  localparam int HC_BUFFER_SIZE = 32;

  typedef logic [31:0] t_hc_control;
  typedef logic [41:0] t_hc_address;

  typedef struct packed {
    t_hc_address               address;
    logic [HC_BUFFER_SIZE-1:0] size;
  } t_hc_buffer;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_DSM_WR = 3'd3,
    ST_DONE   = 3'd4
  } t_state;

  localparam logic [1:0] CL_LEN_1     = 2'b00;
  localparam logic [3:0] REQ_RDLINE_I = 4'h0;
  localparam logic [3:0] REQ_WRLINE_I = 4'h0;
  localparam logic [3:0] RSP_RDLINE   = 4'h0;
  localparam logic [3:0] RSP_WRLINE   = 4'h1;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic        va;
    t_hc_address address;
    logic [15:0] mdata;
  } t_ccip_c0_req_hdr;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic        sop;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic        va;
    t_hc_address address;
    logic [15:0] mdata;
  } t_ccip_c1_req_hdr;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c0_rsp_hdr;

  typedef struct packed {
    t_ccip_c0_req_hdr hdr;
    logic             valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_req_hdr hdr;
    logic [511:0]     data;
    logic             valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c0_rsp_hdr hdr;
    logic [511:0]     data;
    logic             rspValid;
    logic             mmioRdValid;
    logic             mmioWrValid;
  } t_if_ccip_c0_Rx;

  // Completion record: word 0 is the done flag, word 1 the number of lines moved.
  function automatic logic [511:0] dsm_line(input logic [HC_BUFFER_SIZE-1:0] size);
    return {448'b0, size, 32'h0000_0001};
  endfunction

endpackage

// File: rtl/fft_rsp_fifo.sv
// rtl/fft_rsp_fifo.sv - show-ahead synchronous FIFO holding returned read lines
module fft_rsp_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fft_read_engine.sv
// rtl/fft_read_engine.sv - streams a host buffer through a credit-limited read FIFO, then posts a DSM completion line
module fft_read_engine
  import fft_pkg::*;
#(
  parameter int FIFO_DEPTH = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  t_hc_control    hc_control,
  input  t_hc_address    hc_dsm_base,
  input  t_hc_buffer     hc_src,
  output t_if_ccip_c0_Tx c0Tx,
  input  logic           c0TxAlmFull,
  input  t_if_ccip_c0_Rx c0Rx,
  output t_if_ccip_c1_Tx c1Tx,
  input  logic           c1TxAlmFull,
  output logic           out_valid,
  output logic [511:0]   out_data,
  output logic           out_last,
  input  logic           out_ready,
  output logic           busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  t_state      state;
  t_state      state_next;
  logic        start_prev;
  logic        start_edge;
  t_hc_address base_q;
  t_hc_address dsm_q;
  logic [31:0] size_q;
  logic [31:0] req_cnt;
  logic [31:0] rsp_cnt;
  logic [31:0] pop_cnt;
  logic [CW-1:0] credits;
  logic        issue_rd;
  logic        issue_wr;
  logic        latch_job;
  logic        rsp_fire;
  logic        pop_fire;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;
  logic        unused_bits;

  assign start_edge = hc_control[0] & ~start_prev;
  assign busy       = (state != ST_IDLE);
  assign out_valid  = ~fifo_empty;
  assign pop_fire   = out_valid & out_ready;
  assign out_last   = out_valid && (pop_cnt == size_q - 32'd1);

  // Read data is only meaningful while a job is collecting it; anything else on c0Rx is dropped.
  assign rsp_fire = c0Rx.rspValid && (c0Rx.hdr.resp_type == RSP_RDLINE) &&
                    ((state == ST_READ) || (state == ST_DRAIN)) &&
                    (rsp_cnt != size_q) && !fifo_full;

  assign unused_bits = ^{hc_control[31:1], c0Rx.hdr.vc_used, c0Rx.hdr.cl_num,
                         c0Rx.hdr.mdata, c0Rx.mmioRdValid, c0Rx.mmioWrValid, fifo_count};

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue_rd   = 1'b0;
    issue_wr   = 1'b0;
    latch_job  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          latch_job  = 1'b1;
          state_next = (hc_src.size == '0) ? ST_DSM_WR : ST_READ;
        end
      end
      ST_READ: begin
        // Exit waits for the registered count so c0Tx.valid never lingers into DRAIN.
        if (req_cnt == size_q)                        state_next = ST_DRAIN;
        else if (!c0TxAlmFull && (credits != '0))     issue_rd   = 1'b1;
      end
      ST_DRAIN: begin
        if (pop_cnt == size_q) state_next = ST_DSM_WR;
      end
      ST_DSM_WR: begin
        if (!c1TxAlmFull) begin
          issue_wr   = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!hc_control[0]) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_prev <= 1'b0;
      base_q     <= '0;
      dsm_q      <= '0;
      size_q     <= '0;
      req_cnt    <= '0;
      rsp_cnt    <= '0;
      pop_cnt    <= '0;
      credits    <= CW'(FIFO_DEPTH);
      c0Tx       <= '0;
      c1Tx       <= '0;
    end else begin
      start_prev <= hc_control[0];
      if (latch_job) begin
        base_q  <= hc_src.address;
        size_q  <= hc_src.size;
        dsm_q   <= hc_dsm_base;
        req_cnt <= '0;
        rsp_cnt <= '0;
        pop_cnt <= '0;
      end else begin
        if (issue_rd) req_cnt <= req_cnt + 32'd1;
        if (rsp_fire) rsp_cnt <= rsp_cnt + 32'd1;
        if (pop_fire) pop_cnt <= pop_cnt + 32'd1;
      end
      // A response moves a slot from in-flight to FIFO, so only issue and pop change credits.
      credits <= credits - CW'(issue_rd) + CW'(pop_fire);

      c0Tx.valid <= issue_rd;
      if (issue_rd) begin
        c0Tx.hdr.vc_sel   <= 2'b00;
        c0Tx.hdr.cl_len   <= CL_LEN_1;
        c0Tx.hdr.req_type <= REQ_RDLINE_I;
        c0Tx.hdr.va       <= 1'b1;
        c0Tx.hdr.address  <= base_q + t_hc_address'(req_cnt);
        c0Tx.hdr.mdata    <= req_cnt[15:0];
      end

      c1Tx.valid <= issue_wr;
      if (issue_wr) begin
        c1Tx.hdr.vc_sel   <= 2'b00;
        c1Tx.hdr.sop      <= 1'b1;
        c1Tx.hdr.cl_len   <= CL_LEN_1;
        c1Tx.hdr.req_type <= REQ_WRLINE_I;
        c1Tx.hdr.va       <= 1'b1;
        c1Tx.hdr.address  <= dsm_q;
        c1Tx.hdr.mdata    <= 16'h0;
        c1Tx.data         <= dsm_line(size_q);
      end
    end
  end

  fft_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (512)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_fire),
    .push_data (c0Rx.data),
    .pop       (pop_fire),
    .head      (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fft_read_engine.sv
// tb/tb_fft_read_engine.sv - self-checking bench: in-order memory model, stream sink and job scoreboard
module tb_fft_read_engine;
  import fft_pkg::*;

  localparam int DEPTH = 64;

  logic           clk = 1'b0;
  logic           reset;
  t_hc_control    hc_control;
  t_hc_address    hc_dsm_base;
  t_hc_buffer     hc_src;
  t_if_ccip_c0_Tx c0Tx;
  logic           c0TxAlmFull;
  t_if_ccip_c0_Rx c0Rx = '0;
  t_if_ccip_c1_Tx c1Tx;
  logic           c1TxAlmFull;
  logic           out_valid;
  logic [511:0]   out_data;
  logic           out_last;
  logic           out_ready = 1'b0;
  logic           busy;

  always #5 clk = ~clk;

  fft_read_engine #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .hc_control  (hc_control),
    .hc_dsm_base (hc_dsm_base),
    .hc_src      (hc_src),
    .c0Tx        (c0Tx),
    .c0TxAlmFull (c0TxAlmFull),
    .c0Rx        (c0Rx),
    .c1Tx        (c1Tx),
    .c1TxAlmFull (c1TxAlmFull),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  typedef struct { logic [41:0] addr; logic [15:0] mdata; logic [1:0] cl_len; int pops_at; } rd_rec_t;
  typedef struct { logic [511:0] data; logic last; } ln_rec_t;
  typedef struct { logic [41:0] addr; logic [511:0] data; logic [1:0] cl_len; } wr_rec_t;
  typedef struct { logic [41:0] addr; int due; } pend_t;
  typedef struct { logic [41:0] base; logic [31:0] size; logic [41:0] dsm; int pct; logic [63:0] exp_dsm; } vec_t;

  rd_rec_t rd_log[$];
  ln_rec_t ln_log[$];
  wr_rec_t wr_log[$];
  pend_t   pend[$];
  int      cyc = 0;
  int      ready_pct = 100;

  int          errors = 0;
  int          checks = 0;
  t_hc_address job_base;
  logic [31:0] job_size;
  t_hc_address job_dsm;
  int          rs, ls, ws;

  // Memory contents are a fixed hash of the line address.
  function automatic logic [511:0] line_data(input logic [41:0] a);
    logic [511:0] r;
    logic [41:0]  v;
    v = a;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = v[31:0] * 32'h9E37_79B1 + 32'(i) + {22'h0, v[41:32]};
    return r;
  endfunction

  // Host model: logs traffic, returns reads in order after random latency, injects foreign responses.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (c0Tx.valid) begin
      rd_log.push_back('{c0Tx.hdr.address, c0Tx.hdr.mdata, c0Tx.hdr.cl_len, ln_log.size()});
      pend.push_back('{c0Tx.hdr.address, cyc + int'($urandom_range(2, 8))});
    end
    if (c1Tx.valid) wr_log.push_back('{c1Tx.hdr.address, c1Tx.data, c1Tx.hdr.cl_len});
    out_ready = (int'($urandom_range(1, 100)) <= ready_pct);
    if (out_valid && out_ready) ln_log.push_back('{out_data, out_last});
    c0Rx = '0;
    if (pend.size() != 0 && pend[0].due <= cyc && $urandom_range(0, 3) != 0) begin
      c0Rx.rspValid      = 1'b1;
      c0Rx.hdr.resp_type = RSP_RDLINE;
      c0Rx.data          = line_data(pend[0].addr);
      pend.delete(0);
    end else if ($urandom_range(0, 7) == 0) begin
      c0Rx.data = {16{$urandom()}};
      if ($urandom_range(0, 1) == 1) begin
        c0Rx.rspValid      = 1'b1;
        c0Rx.hdr.resp_type = RSP_WRLINE;
      end else begin
        c0Rx.mmioRdValid = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input int idx, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic start_job(input t_hc_address base, input logic [31:0] size, input t_hc_address dsm, input int pct);
    int n;
    n = 0;
    while (pend.size() != 0 && n < 400) begin tick(); n++; end
    check("drain_before_start", pend.size(), 0);
    hc_control = '0;
    tick();
    job_base = base; job_size = size; job_dsm = dsm;
    rs = rd_log.size(); ls = ln_log.size(); ws = wr_log.size();
    hc_src.address = base; hc_src.size = size; hc_dsm_base = dsm;
    ready_pct = pct;
    hc_control = 32'h1;
    tick();
    hc_src.address = base ^ 42'h2A_AAAA_5555;
    hc_src.size    = size + 32'd9;
    hc_dsm_base    = ~dsm;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (wr_log.size() == ws && n < bound) begin tick(); n++; end
    repeat (4) tick();
    check("dsm_write_count", wr_log.size() - ws, 1);
  endtask

  task automatic finish_job();
    int n;
    hc_control = '0;
    n = 0;
    while (busy && n < 6) begin tick(); n++; end
    check("busy_after_clear", busy, 0);
  endtask

  task automatic verify_reads(input int limit);
    for (int k = 0; k < limit && rs + k < rd_log.size(); k++) begin
      check("read_addr", rd_log[rs+k].addr, job_base + t_hc_address'(k));
      check("read_mdata", rd_log[rs+k].mdata, 16'(k));
      check("read_len", rd_log[rs+k].cl_len, CL_LEN_1);
      check("credit_bound", (k + 1) <= DEPTH + (rd_log[rs+k].pops_at - ls), 1);
    end
  endtask

  task automatic verify_lines(input int limit);
    for (int k = 0; k < limit && ls + k < ln_log.size(); k++) begin
      check_line("line_data", k, ln_log[ls+k].data, line_data(job_base + t_hc_address'(k)));
      check("line_last", ln_log[ls+k].last, k == int'(job_size) - 1);
    end
  endtask

  task automatic verify_job(input logic [63:0] exp_dsm);
    check("read_count", rd_log.size() - rs, job_size);
    verify_reads(int'(job_size));
    check("line_count", ln_log.size() - ls, job_size);
    verify_lines(int'(job_size));
    if (wr_log.size() > ws) begin
      check("dsm_addr", wr_log[ws].addr, job_dsm);
      check("dsm_data", wr_log[ws].data[63:0], exp_dsm);
      check("dsm_upper_zero", |wr_log[ws].data[511:64], 0);
      check("dsm_len", wr_log[ws].cl_len, CL_LEN_1);
    end
  endtask

  initial begin
    vec_t vecs[4];
    int   n, snap_rd, snap_wr, snap_ln;
    t_hc_address b;
    logic [31:0] s;

    vecs[0] = '{42'h1000,          32'd4,  42'h2_0000, 100, 64'h0000_0004_0000_0001};
    vecs[1] = '{42'h3_0000_0000,   32'd0,  42'h40,     100, 64'h0000_0000_0000_0001};
    vecs[2] = '{42'h123_4567_89AB, 32'd1,  42'h7_7700,  60, 64'h0000_0001_0000_0001};
    vecs[3] = '{42'h8_0000,        32'd17, 42'h900,     50, 64'h0000_0011_0000_0001};

    reset = 1'b1; hc_control = '0; hc_src = '0; hc_dsm_base = '0;
    c0TxAlmFull = 1'b0; c1TxAlmFull = 1'b0;
    repeat (3) tick();
    check("reset_c0_valid", c0Tx.valid, 0);
    check("reset_c1_valid", c1Tx.valid, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      start_job(vecs[v].base, vecs[v].size, vecs[v].dsm, vecs[v].pct);
      wait_done(2000);
      finish_job();
      verify_job(vecs[v].exp_dsm);
    end

    // Backpressure from the sink: credits must cap outstanding work at the FIFO depth.
    start_job(42'h5_0000, 32'd200, 42'h100, 0);
    repeat (300) tick();
    check("stall_reads", rd_log.size() - rs, DEPTH);
    check("stall_lines", ln_log.size() - ls, 0);
    ready_pct = 100;
    wait_done(3000);
    finish_job();
    verify_job({32'd200, 32'h1});

    // Read-channel almost-full window in the middle of READ.
    start_job(42'h6_1000, 32'd48, 42'h180, 70);
    n = 0;
    while (rd_log.size() - rs < 10 && n < 200) begin tick(); n++; end
    snap_rd = rd_log.size();
    c0TxAlmFull = 1'b1;
    repeat (20) tick();
    check("almfull_window_reads", rd_log.size() - snap_rd, 0);
    c0TxAlmFull = 1'b0;
    wait_done(2000);
    finish_job();
    verify_job({32'd48, 32'h1});

    // Reset part way through a job, then a short fresh job.
    start_job(42'h7_2000, 32'd32, 42'h1C0, 100);
    n = 0;
    while (ln_log.size() - ls < 10 && n < 500) begin tick(); n++; end
    reset = 1'b1;
    hc_control = '0;
    tick();
    check("rst_c0_valid", c0Tx.valid, 0);
    check("rst_c1_valid", c1Tx.valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    verify_reads(32);
    verify_lines(32);
    snap_ln = ln_log.size();
    snap_wr = wr_log.size();
    n = 0;
    while (pend.size() != 0 && n < 400) begin tick(); n++; end
    repeat (5) tick();
    check("late_rsp_lines", ln_log.size() - snap_ln, 0);
    check("late_rsp_out_valid", out_valid, 0);
    check("late_rsp_dsm", wr_log.size() - snap_wr, 0);
    start_job(42'h9_3000, 32'd2, 42'h200, 100);
    wait_done(500);
    finish_job();
    verify_job({32'd2, 32'h1});

    // Start held high after DONE must not relaunch until it toggles.
    start_job(42'hA_0000, 32'd3, 42'h240, 100);
    wait_done(500);
    verify_job({32'd3, 32'h1});
    snap_rd = rd_log.size();
    snap_wr = wr_log.size();
    hc_src.address = 42'hB_0000; hc_src.size = 32'd5; hc_dsm_base = 42'h280;
    repeat (30) tick();
    check("held_start_reads", rd_log.size() - snap_rd, 0);
    check("held_start_dsm", wr_log.size() - snap_wr, 0);
    check("held_start_busy", busy, 1);
    start_job(42'hB_0000, 32'd5, 42'h280, 100);
    wait_done(500);
    finish_job();
    verify_job({32'd5, 32'h1});

    for (int j = 0; j < 4; j++) begin
      b = t_hc_address'($urandom()) << 4;
      s = 32'($urandom_range(1, 90));
      start_job(b, s, t_hc_address'($urandom()), int'($urandom_range(20, 100)));
      wait_done(3000);
      finish_job();
      verify_job({s, 32'h1});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
